// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] FETCH_NOP      = 32'h0000_0000;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: load beats hold beats increment.
module pc_reg #(
  parameter int unsigned          BIT_ADDR = 32,
  parameter logic [BIT_ADDR-1:0]  RESET_PC = '0,
  parameter logic [BIT_ADDR-1:0]  PC_STEP  = BIT_ADDR'(1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [BIT_ADDR-1:0] load_val,
  input  logic                hold,
  output logic [BIT_ADDR-1:0] pc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (!hold) begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, captures the combinational
// instruction word into IF/ID, handles stall/redirect/halt.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned          BIT_ADDR = 32,
  parameter int unsigned          BIT_DATO = 32,
  parameter logic [BIT_ADDR-1:0]  RESET_PC = BIT_ADDR'(FETCH_RESET_PC),
  parameter logic [BIT_ADDR-1:0]  PC_STEP  = BIT_ADDR'(1),
  parameter logic [BIT_DATO-1:0]  NOP_INS  = BIT_DATO'(FETCH_NOP)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [BIT_ADDR-1:0] redirect_pc,
  input  logic                halt_req,
  input  logic                restart,
  input  logic [BIT_DATO-1:0] ins_in,
  output logic [BIT_ADDR-1:0] pc_out,
  output logic [BIT_DATO-1:0] if_id_ins,
  output logic [BIT_ADDR-1:0] if_id_pc,
  output logic                if_id_valid,
  output logic                halted,
  output logic [31:0]         fetch_count
);

  fetch_state_t          state;
  logic                  pc_load;
  logic                  pc_hold;
  logic [BIT_ADDR-1:0]   pc_load_val;

  pc_reg #(
    .BIT_ADDR (BIT_ADDR),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (pc_load_val),
    .hold     (pc_hold),
    .pc       (pc_out)
  );

  // PC only advances on a real capture in RUN
  always_comb begin
    pc_load     = 1'b0;
    pc_hold     = 1'b1;
    pc_load_val = redirect_pc;
    unique case (state)
      RUN: begin
        if (redirect) begin
          pc_load = 1'b1;
        end else if (!halt_req && !stall) begin
          pc_hold = 1'b0;
        end
      end
      HALT: begin
        if (restart) begin
          pc_load     = 1'b1;
          pc_load_val = RESET_PC;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      if_id_ins   <= NOP_INS;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          state       <= RUN;
          if_id_valid <= 1'b0;
        end
        RUN: begin
          if (redirect) begin
            if_id_valid <= 1'b0;
            if_id_ins   <= NOP_INS;
          end else if (halt_req) begin
            if_id_valid <= 1'b0;
            halted      <= 1'b1;
            state       <= HALT;
          end else if (!stall) begin
            if_id_ins   <= ins_in;
            if_id_pc    <= pc_out;
            if_id_valid <= 1'b1;
            if (fetch_count != '1) begin
              fetch_count <= fetch_count + 32'd1;
            end
          end
        end
        HALT: begin
          if_id_valid <= 1'b0;
          if (restart) begin
            halted <= 1'b0;
            state  <= BOOT;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: run, stall, redirect, halt,
// async reset, PC wrap and counter saturation.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        restart = 1'b0;
  logic [31:0] ins_in;
  logic [31:0] pc_out;
  logic [31:0] if_id_ins;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic        rst4 = 1'b0;
  logic [31:0] ins4;
  logic [3:0]  pc4;
  logic [31:0] ins4_q;
  logic [3:0]  ipc4;
  logic        val4;
  logic        halt4;
  logic [31:0] cnt4;

  logic [31:0] mem [16];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign ins_in = mem[pc_out[3:0]];
  assign ins4   = 32'hA00 + {28'h0, pc4};

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_req),
    .restart     (restart),
    .ins_in      (ins_in),
    .pc_out      (pc_out),
    .if_id_ins   (if_id_ins),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  fetch_unit #(.BIT_ADDR(4)) dut4 (
    .clk         (clk),
    .rst         (rst4),
    .stall       (1'b0),
    .redirect    (1'b0),
    .redirect_pc (4'h0),
    .halt_req    (1'b0),
    .restart     (1'b0),
    .ins_in      (ins4),
    .pc_out      (pc4),
    .if_id_ins   (ins4_q),
    .if_id_pc    (ipc4),
    .if_id_valid (val4),
    .halted      (halt4),
    .fetch_count (cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc_out, 0);
    chk({tag, "_ins"}, if_id_ins, 0);
    chk({tag, "_ipc"}, if_id_pc, 0);
    chk({tag, "_val"}, if_id_valid, 0);
    chk({tag, "_halt"}, halted, 0);
    chk({tag, "_cnt"}, fetch_count, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;

    #12;
    chk_reset_vals("rst0");
    @(negedge clk);
    rst = 1'b1;

    step();
    chk("boot_pc", pc_out, 0);
    chk("boot_val", if_id_valid, 0);
    step();
    chk("f1_ins", if_id_ins, 32'h11);
    chk("f1_ipc", if_id_pc, 0);
    chk("f1_val", if_id_valid, 1);
    chk("f1_pc", pc_out, 1);
    chk("f1_cnt", fetch_count, 1);
    step();
    chk("f2_ins", if_id_ins, 32'h22);
    chk("f2_pc", pc_out, 2);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_pc", pc_out, 2);
      chk("stl_ins", if_id_ins, 32'h22);
      chk("stl_ipc", if_id_pc, 1);
      chk("stl_val", if_id_valid, 1);
      chk("stl_cnt", fetch_count, 2);
    end
    stall = 1'b0;
    step();
    chk("f3_ins", if_id_ins, 32'h33);
    chk("f3_cnt", fetch_count, 3);
    step();
    chk("f4_ins", if_id_ins, 32'h103);
    chk("f4_pc", pc_out, 4);

    redirect    = 1'b1;
    redirect_pc = 32'd9;
    stall       = 1'b1;
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    chk("rd_val", if_id_valid, 0);
    chk("rd_ins", if_id_ins, 0);
    chk("rd_pc", pc_out, 9);
    chk("rd_cnt", fetch_count, 4);
    step();
    chk("rd_ipc", if_id_pc, 9);
    chk("rd_tins", if_id_ins, 32'h109);
    chk("rd_tval", if_id_valid, 1);
    chk("rd_cnt2", fetch_count, 5);

    redirect    = 1'b1;
    redirect_pc = 32'd5;
    step();
    redirect = 1'b0;
    chk("rd5_pc", pc_out, 5);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("hlt_on", halted, 1);
    chk("hlt_val", if_id_valid, 0);
    redirect    = 1'b1;
    redirect_pc = 32'd7;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hlt_pc", pc_out, 5);
      chk("hlt_v", if_id_valid, 0);
      chk("hlt_h", halted, 1);
    end
    redirect = 1'b0;

    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("rs_pc", pc_out, 0);
    chk("rs_halt", halted, 0);
    chk("rs_val", if_id_valid, 0);
    step();
    chk("rs_boot", if_id_valid, 0);
    chk("rs_bpc", pc_out, 0);
    step();
    chk("rs_ipc", if_id_pc, 0);
    chk("rs_ins", if_id_ins, 32'h11);
    chk("rs_v", if_id_valid, 1);
    chk("rs_cnt", fetch_count, 6);
    step();
    chk("rs_ins2", if_id_ins, 32'h22);

    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("ar_boot", if_id_valid, 0);
    step();
    chk("ar_ins", if_id_ins, 32'h11);
    chk("ar_pc", pc_out, 1);
    chk("ar_cnt", fetch_count, 1);

    @(negedge clk);
    rst4 = 1'b1;
    step();
    for (int i = 0; i < 15; i++) step();
    chk("w_pc", pc4, 15);
    chk("w_cnt", cnt4, 15);
    force dut4.fetch_count = 32'hFFFF_FFFE;
    #1;
    release dut4.fetch_count;
    chk("w_force", cnt4, 32'hFFFF_FFFE);
    step();
    chk("w_ipc", ipc4, 15);
    chk("w_ins", ins4_q, 32'hA0F);
    chk("w_wrap", pc4, 0);
    chk("sat1", cnt4, 32'hFFFF_FFFF);
    step();
    chk("sat2", cnt4, 32'hFFFF_FFFF);
    chk("w_ipc0", ipc4, 0);
    chk("w_pc1", pc4, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the instruction memory `mem_ins`. It owns the program counter and drives the memory address. It captures the combinational instruction word returned by the memory into the IF/ID pipeline register. It handles stall, branch redirect, flush and halt from later stages.

## Interface
Parameters:
- `BIT_ADDR`, 32, width of the PC and of the instruction-memory address.
- `BIT_DATO`, 32, instruction word width.
- `RESET_PC`, 0, PC value loaded at reset and on restart.
- `PC_STEP`, 1, PC increment; memory is word-addressed.
- `NOP_INS`, 32'h0000_0000, word placed in `if_id_ins` when the slot is invalid.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall`  in  1  decode cannot accept; hold PC and IF/ID.
- `redirect`  in  1  taken branch/jump; load `redirect_pc`.
- `redirect_pc`  in  BIT_ADDR  branch target.
- `halt_req`  in  1  stop fetching after the current cycle.
- `restart`  in  1  leave HALT and resume at `RESET_PC`.
- `ins_in`  in  BIT_DATO  instruction from `mem_ins.datOutRa`.
- `pc_out`  out  BIT_ADDR  address to `mem_ins.addrRa`; equals the PC register.
- `if_id_ins`  out  BIT_DATO  latched instruction.
- `if_id_pc`  out  BIT_ADDR  PC of the latched instruction.
- `if_id_valid`  out  1  IF/ID slot holds a real instruction.
- `halted`  out  1  high while in HALT.
- `fetch_count`  out  32  number of instructions delivered valid; saturates at 2^32−1.

## Operation
- Reset values (asynchronous, while `rst`=0): PC=`RESET_PC`, `if_id_ins`=`NOP_INS`, `if_id_pc`=0, `if_id_valid`=0, `halted`=0, `fetch_count`=0, state=BOOT.
- States:
  - BOOT: one cycle, no capture, `if_id_valid` stays 0. Next state is RUN. `redirect`, `stall` and `halt_req` are ignored in BOOT.
  - RUN: normal fetch.
  - HALT: PC frozen, `if_id_valid`=0, `halted`=1.
- RUN priority per cycle is redirect > halt_req > stall > normal.
  - redirect: PC←`redirect_pc`, `if_id_valid`←0, `if_id_ins`←`NOP_INS`. The wrong-path word is squashed.
  - halt_req: `if_id_valid`←0 and PC holds. Next state is HALT.
  - stall: PC, `if_id_*` and `fetch_count` all hold.
  - normal: `if_id_ins`←`ins_in`, `if_id_pc`←PC, `if_id_valid`←1, PC←PC+`PC_STEP`, `fetch_count`+1.
- HALT: `restart`=1 loads PC←`RESET_PC` and moves to BOOT. All other inputs are ignored.
- PC arithmetic is modulo 2^BIT_ADDR; it wraps from all-ones to 0 silently. Only the low address bits reach the memory, and out-of-range addresses are the memory's concern.
- `fetch_count` saturates: at all-ones it holds.

## Timing
- The memory read is combinational. The instruction at address PC is captured on the same edge that advances PC, so fetch-to-IF/ID latency is 1 cycle.
- First valid instruction (address `RESET_PC`) appears on `if_id_*` 2 edges after `rst` deasserts: the BOOT edge plus the capture edge.
- After redirect at edge N, there is one bubble at N. The target instruction is valid after edge N+1.
- `stall` is sampled on the edge. While it is held, the outputs are bit-stable.
- If reset asserts mid-operation, all state clears immediately without waiting for the clock, and any in-flight slot is discarded.

## Structure
- Shared package `fetch_pkg` holds:
  - the state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2);
  - the default `NOP_INS`;
  - the default `RESET_PC`.
- One sub-module `pc_reg` holds the PC register with async reset, load (redirect/restart), hold (stall/halt) and increment. The top level holds the FSM, the IF/ID register and the counter.
- Target size is roughly 150–250 lines of RTL.

## Test plan
- Reset then free run with memory preloaded 0x11,0x22,0x33: `pc_out` reads 0,0,1,2,3; `if_id_ins` reads 0x11,0x22,0x33 with valid from the 2nd edge; `fetch_count`=3 after 3 deliveries.
- `stall` for 3 cycles while `if_id_ins`=0x22: PC, `if_id_*` and `fetch_count` are unchanged for 3 cycles; on release 0x33 follows.
- `redirect`=1 with `redirect_pc`=9 at PC=4: next `if_id_valid`=0 and `pc_out`=9; one cycle later `if_id_pc`=9 with valid. `redirect` and `stall` asserted together: redirect wins.
- `halt_req` at PC=5: `halted`=1, `pc_out` stays 5 and valid stays 0 for 10 cycles. `restart`: `pc_out`=0, BOOT, then first valid at `if_id_pc`=0.
- `rst` pulsed low mid-run (asynchronous, between edges): all outputs return to their reset values immediately, and the sequence restarts from `RESET_PC`.
- With `BIT_ADDR`=4 and PC=15: PC wraps to 0 and the captured `if_id_pc`=15; also preset `fetch_count` near max and confirm it saturates.
